// File: rtl/memaccess_pkg.sv
// Shared opcodes, funct3 codes and FSM state type for the memory-access stage.
package memaccess_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   // Halfwords need even addresses, words need 4-byte alignment; bytes never fault.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic res;
      res = 1'b0;
      if (f3 == F3_H || f3 == F3_HU)
         res = off[0];
      else if (f3 == F3_W)
         res = (off != 2'b00);
      return res;
   endfunction

endpackage

// File: rtl/memaccess_ldext.sv
// Load-data alignment: shifts the addressed bytes down to bit 0 and sign/zero extends them.
module memaccess_ldext
   import memaccess_pkg::*;
(
   input  logic [31:0] rdat,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;

   assign shifted = rdat >> {offset, 3'b000};

   always_comb begin
      data = shifted;
      case (funct3)
         F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   data = {24'h000000, shifted[7:0]};
         F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   data = {16'h0000, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/memaccess_lsu.sv
// Memory-access stage: pass-through for ALU ops, req/gnt/rvld data-memory transactions
// for loads and stores, with misalignment and timeout reporting toward writeback.
module memaccess_lsu
   import memaccess_pkg::*;
#(
   parameter int TMO_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ma_vld,
   output logic        ma_rdy,
   input  logic [31:0] ma_inst,
   input  logic [31:0] ma_dat,
   input  logic [31:0] ma_addr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_adr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdat,
   input  logic        dmem_gnt,
   input  logic        dmem_rvld,
   input  logic [31:0] dmem_rdat,
   output logic        wb_vld,
   output logic [31:0] wb_inst,
   output logic [31:0] wb_dat,
   output logic        wb_err
);

   localparam int CW = $clog2(TMO_CYC + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

   state_t      state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [31:0] inst_reg, inst_next;
   logic [31:0] adr_reg, adr_next;

   logic        req_reg, req_next;
   logic        we_reg, we_next;
   logic [31:0] dadr_reg, dadr_next;
   logic [3:0]  be_reg, be_next;
   logic [31:0] wdat_reg, wdat_next;

   logic        wb_vld_reg, wb_vld_next;
   logic [31:0] wb_inst_reg, wb_inst_next;
   logic [31:0] wb_dat_reg, wb_dat_next;
   logic        wb_err_reg, wb_err_next;

   logic [6:0]  in_opc;
   logic [2:0]  in_f3;
   logic [1:0]  in_off;
   logic        in_load, in_store, in_mem, in_misal;
   logic [3:0]  st_be;
   logic [31:0] st_wdat;
   logic [31:0] ld_data;
   logic        tmo;

   assign in_opc   = ma_inst[6:0];
   assign in_f3    = ma_inst[14:12];
   assign in_off   = ma_dat[1:0];
   assign in_load  = (in_opc == OPC_LOAD) && (in_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   assign in_store = (in_opc == OPC_STORE) && (in_f3 inside {F3_B, F3_H, F3_W});
   assign in_mem   = in_load || in_store;
   assign in_misal = is_misaligned(in_f3, in_off);
   assign tmo      = (cnt_reg >= TMO_LAST);

   // Byte lane enables follow access size; loads use the same lanes for visibility on the bus.
   assign st_be = (in_f3 == F3_B || in_f3 == F3_BU) ? (4'b0001 << in_off) :
                  (in_f3 == F3_H || in_f3 == F3_HU) ? (4'b0011 << in_off) : 4'hF;

   // Replicate store data so every lane carries the byte it would need at any offset.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign st_wdat[gi*8 +: 8] = (in_f3 == F3_B) ? ma_addr[7:0] :
                                  (in_f3 == F3_H) ? ma_addr[(gi%2)*8 +: 8] :
                                                    ma_addr[gi*8 +: 8];
   end

   memaccess_ldext u_ldext (
      .rdat   (dmem_rdat),
      .offset (adr_reg[1:0]),
      .funct3 (inst_reg[14:12]),
      .data   (ld_data)
   );

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      inst_next    = inst_reg;
      adr_next     = adr_reg;
      req_next     = req_reg;
      we_next      = we_reg;
      dadr_next    = dadr_reg;
      be_next      = be_reg;
      wdat_next    = wdat_reg;
      wb_vld_next  = 1'b0;
      wb_inst_next = wb_inst_reg;
      wb_dat_next  = wb_dat_reg;
      wb_err_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (ma_vld) begin
               if (in_mem && !in_misal) begin
                  state_next = REQ;
                  cnt_next   = '0;
                  inst_next  = ma_inst;
                  adr_next   = ma_dat;
                  req_next   = 1'b1;
                  we_next    = in_store;
                  dadr_next  = {ma_dat[31:2], 2'b00};
                  be_next    = st_be;
                  wdat_next  = in_store ? st_wdat : 32'h0;
               end else begin
                  wb_vld_next  = 1'b1;
                  wb_inst_next = ma_inst;
                  wb_dat_next  = ma_dat;
                  wb_err_next  = in_mem;
               end
            end
         end
         REQ: begin
            if (dmem_gnt) begin
               req_next = 1'b0;
               cnt_next = cnt_reg + 1'b1;
               if (we_reg) begin
                  state_next   = IDLE;
                  wb_vld_next  = 1'b1;
                  wb_inst_next = inst_reg;
                  wb_dat_next  = adr_reg;
               end else begin
                  state_next = WAIT;
               end
            end else if (tmo) begin
               state_next   = IDLE;
               req_next     = 1'b0;
               wb_vld_next  = 1'b1;
               wb_err_next  = 1'b1;
               wb_inst_next = inst_reg;
               wb_dat_next  = adr_reg;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT: begin
            if (dmem_rvld) begin
               state_next   = IDLE;
               wb_vld_next  = 1'b1;
               wb_inst_next = inst_reg;
               wb_dat_next  = ld_data;
            end else if (tmo) begin
               state_next   = IDLE;
               wb_vld_next  = 1'b1;
               wb_err_next  = 1'b1;
               wb_inst_next = inst_reg;
               wb_dat_next  = adr_reg;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         inst_reg    <= '0;
         adr_reg     <= '0;
         req_reg     <= 1'b0;
         we_reg      <= 1'b0;
         dadr_reg    <= '0;
         be_reg      <= '0;
         wdat_reg    <= '0;
         wb_vld_reg  <= 1'b0;
         wb_inst_reg <= '0;
         wb_dat_reg  <= '0;
         wb_err_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         inst_reg    <= inst_next;
         adr_reg     <= adr_next;
         req_reg     <= req_next;
         we_reg      <= we_next;
         dadr_reg    <= dadr_next;
         be_reg      <= be_next;
         wdat_reg    <= wdat_next;
         wb_vld_reg  <= wb_vld_next;
         wb_inst_reg <= wb_inst_next;
         wb_dat_reg  <= wb_dat_next;
         wb_err_reg  <= wb_err_next;
      end
   end

   assign ma_rdy    = (state_reg == IDLE) && !rst;
   assign dmem_req  = req_reg;
   assign dmem_we   = we_reg;
   assign dmem_adr  = dadr_reg;
   assign dmem_be   = be_reg;
   assign dmem_wdat = wdat_reg;
   assign wb_vld    = wb_vld_reg;
   assign wb_inst   = wb_inst_reg;
   assign wb_dat    = wb_dat_reg;
   assign wb_err    = wb_err_reg;

endmodule
